// File: rtl/batch_scheduler.sv
// ============================================================================
// Module   : batch_scheduler
// Purpose  : Batch/phase sequencer for the batch filter; optional flush via
//            macro BATCH_SCHEDULER_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module batch_scheduler #(
  parameter int DEPTH_DS   = 15,
  parameter int RES_DELAY  = 4,
  parameter int PROP_DELAY = 1,
  parameter int VALID_COMP = 46,
  parameter int VALID_TIME = 75,
  parameter int BW         = $clog2(DEPTH_DS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef BATCH_SCHEDULER_FLUSH_EN
  input  logic          flush,
  output logic          flushBusy,
`endif
  output logic [BW+1:0] addrIn,
  output logic [BW+1:0] addrLH,
  output logic [BW+1:0] addrFR,
  output logic [BW+1:0] addrBR,
  output logic [BW:0]   addrResIn,
  output logic [BW:0]   addrResOutF,
  output logic [BW:0]   addrResOutB,
  output logic          propagate,
  output logic [1:0]    cycle,
  output logic          cycleEnd,
  output logic          validCompute,
  output logic          valid
);

  localparam int              VCW    = $clog2(VALID_TIME + 1);
  localparam logic [BW-1:0]   c_LAST = BW'(DEPTH_DS - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    RUN     = 2'd2
  } state_t;

  logic [BW-1:0]  r_batCnt;
  logic [BW-1:0]  r_batCntRev;
  logic [1:0]     r_cycle;
  logic [1:0]     r_cycleLH;
  logic [1:0]     r_cycleCalc;
  logic [BW-1:0]  r_tapCnt [RES_DELAY];
  logic [BW-1:0]  r_tapRev [RES_DELAY];
  logic           r_tapCyc [RES_DELAY];
  logic           r_propTap [PROP_DELAY];
  logic [VCW-1:0] r_vcnt;
  logic [VCW-1:0] w_vcntNext;
  state_t         r_state;
  state_t         w_stateNext;
  logic           w_flush;
  logic           w_hold;

`ifdef BATCH_SCHEDULER_FLUSH_EN
  logic [$clog2(RES_DELAY+1)-1:0] r_flushCnt;

  always_ff @(posedge clk) begin
    if (!rst)
      r_flushCnt <= '0;
    else if (flush)
      r_flushCnt <= ($clog2(RES_DELAY+1))'(RES_DELAY);
    else if (en && r_flushCnt != '0)
      r_flushCnt <= r_flushCnt - 1'b1;
  end

  assign flushBusy = (r_flushCnt != '0);
  assign w_flush   = flush;
  assign w_hold    = flushBusy;
`else
  assign w_flush = 1'b0;
  assign w_hold  = 1'b0;
`endif

  assign cycle    = r_cycle;
  assign cycleEnd = (r_batCnt == c_LAST);

  // Batch counters and phase rotation; phases advance only at batch end.
  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      r_batCnt    <= '0;
      r_batCntRev <= c_LAST;
      r_cycle     <= 2'd0;
      r_cycleLH   <= 2'd3;
      r_cycleCalc <= 2'd1;
    end else if (en) begin
      if (cycleEnd) begin
        r_batCnt    <= '0;
        r_batCntRev <= c_LAST;
        r_cycle     <= r_cycle + 2'd1;
        r_cycleLH   <= r_cycleLH + 2'd1;
        r_cycleCalc <= r_cycleCalc + 2'd1;
      end else begin
        r_batCnt    <= r_batCnt + 1'b1;
        r_batCntRev <= r_batCntRev - 1'b1;
      end
    end
  end

  // Delay lines feeding the result-memory addresses and propagate strobe.
  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      for (int i = 0; i < RES_DELAY; i++) begin
        r_tapCnt[i] <= '0;
        r_tapRev[i] <= c_LAST;
        r_tapCyc[i] <= 1'b0;
      end
      for (int i = 0; i < PROP_DELAY; i++)
        r_propTap[i] <= 1'b1;
    end else if (en) begin
      r_tapCnt[0]  <= r_batCnt;
      r_tapRev[0]  <= r_batCntRev;
      r_tapCyc[0]  <= r_cycle[0];
      r_propTap[0] <= ~cycleEnd;
      for (int i = 1; i < RES_DELAY; i++) begin
        r_tapCnt[i] <= r_tapCnt[i-1];
        r_tapRev[i] <= r_tapRev[i-1];
        r_tapCyc[i] <= r_tapCyc[i-1];
      end
      for (int i = 1; i < PROP_DELAY; i++)
        r_propTap[i] <= r_propTap[i-1];
    end
  end

  assign propagate = r_propTap[PROP_DELAY-1];

  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      addrIn      <= '0;
      addrLH      <= '0;
      addrFR      <= '0;
      addrBR      <= '0;
      addrResIn   <= '0;
      addrResOutF <= '0;
      addrResOutB <= '0;
    end else if (en) begin
      addrIn      <= {r_batCnt, r_cycle};
      addrLH      <= {r_batCntRev, r_cycleLH};
      addrFR      <= {r_batCnt, r_cycleCalc};
      addrBR      <= {r_batCntRev, r_cycleCalc};
      addrResIn   <= {r_tapCnt[RES_DELAY-1], r_tapCyc[RES_DELAY-1]};
      addrResOutF <= {r_tapCnt[RES_DELAY-1], ~r_tapCyc[RES_DELAY-1]};
      addrResOutB <= {r_tapRev[RES_DELAY-1], ~r_tapCyc[RES_DELAY-1]};
    end
  end

  assign w_vcntNext = r_vcnt + VCW'(1);

  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      r_state <= FILL;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (en && r_vcnt != VCW'(VALID_TIME))
        r_vcnt <= w_vcntNext;
    end
  end

  // Flags switch on the same edge the threshold count is reached.
  always_comb begin
    w_stateNext  = r_state;
    validCompute = 1'b0;
    valid        = 1'b0;
    case (r_state)
      FILL: begin
        if (en && w_vcntNext == VCW'(VALID_COMP))
          w_stateNext = COMPUTE;
      end
      COMPUTE: begin
        validCompute = ~w_hold;
        if (en && w_vcntNext == VCW'(VALID_TIME))
          w_stateNext = RUN;
      end
      RUN: begin
        validCompute = ~w_hold;
        valid        = ~w_hold;
      end
      default: w_stateNext = FILL;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_batch_scheduler.sv
// ============================================================================
// Module   : tb_batch_scheduler
// Purpose  : Directed self-checking bench for batch_scheduler (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_batch_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] addrIn, addrLH, addrFR, addrBR;
  logic [4:0] addrResIn, addrResOutF, addrResOutB;
  logic       propagate;
  logic [1:0] cycle;
  logic       cycleEnd;
  logic       validCompute;
  logic       valid;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  batch_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .addrIn      (addrIn),
    .addrLH      (addrLH),
    .addrFR      (addrFR),
    .addrBR      (addrBR),
    .addrResIn   (addrResIn),
    .addrResOutF (addrResOutF),
    .addrResOutB (addrResOutB),
    .propagate   (propagate),
    .cycle       (cycle),
    .cycleEnd    (cycleEnd),
    .validCompute(validCompute),
    .valid       (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: expected outputs after n enabled ticks since reset.
  function automatic logic [5:0] m_addrIn(int t);
    int k;
    if (t == 0) return 6'd0;
    k = t - 1;
    return {4'(k % 15), 2'((k / 15) % 4)};
  endfunction

  function automatic logic [5:0] m_addrLH(int t);
    int k;
    if (t == 0) return 6'd0;
    k = t - 1;
    return {4'(14 - k % 15), 2'((k / 15 + 3) % 4)};
  endfunction

  function automatic logic [5:0] m_addrFR(int t);
    int k;
    if (t == 0) return 6'd0;
    k = t - 1;
    return {4'(k % 15), 2'((k / 15 + 1) % 4)};
  endfunction

  function automatic logic [5:0] m_addrBR(int t);
    int k;
    if (t == 0) return 6'd0;
    k = t - 1;
    return {4'(14 - k % 15), 2'((k / 15 + 1) % 4)};
  endfunction

  function automatic logic m_prop(int t);
    if (t == 0) return 1'b1;
    return ((t - 1) % 15) != 14;
  endfunction

  function automatic logic [4:0] m_resIn(int t);
    int m;
    m = t - 5;
    if (t == 0 || m < 0) return 5'd0;
    return {4'(m % 15), 1'((m / 15) % 2)};
  endfunction

  function automatic logic [4:0] m_resF(int t);
    int m;
    m = t - 5;
    if (t == 0) return 5'd0;
    if (m < 0) return 5'b00001;
    return {4'(m % 15), ~1'((m / 15) % 2)};
  endfunction

  function automatic logic [4:0] m_resB(int t);
    int m;
    m = t - 5;
    if (t == 0) return 5'd0;
    if (m < 0) return 5'b11101;
    return {4'(14 - m % 15), ~1'((m / 15) % 2)};
  endfunction

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    if (e) n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    n   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (addrIn !== 6'd0) begin errors++; $display("FAIL reset_addrIn got %0h exp 0", addrIn); end
    checks++; if (addrLH !== 6'd0) begin errors++; $display("FAIL reset_addrLH got %0h exp 0", addrLH); end
    checks++; if (addrResOutB !== 5'd0) begin errors++; $display("FAIL reset_addrResOutB got %0h exp 0", addrResOutB); end
    checks++; if (propagate !== 1'b1) begin errors++; $display("FAIL reset_propagate got %0b exp 1", propagate); end
    checks++; if (cycle !== 2'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", cycle); end
    checks++; if (cycleEnd !== 1'b0) begin errors++; $display("FAIL reset_cycleEnd got %0b exp 0", cycleEnd); end
    checks++; if ({validCompute, valid} !== 2'b00) begin errors++; $display("FAIL reset_valid got %0b%0b exp 00", validCompute, valid); end
  endtask

  task automatic test_first_edge();
    do_reset();
    step(1'b1);
    checks++; if (addrIn !== 6'b0000_00) begin errors++; $display("FAIL edge1_addrIn got %b exp 000000", addrIn); end
    checks++; if (addrLH !== 6'b1110_11) begin errors++; $display("FAIL edge1_addrLH got %b exp 111011", addrLH); end
    checks++; if (addrFR !== 6'b0000_01) begin errors++; $display("FAIL edge1_addrFR got %b exp 000001", addrFR); end
    checks++; if (addrBR !== 6'b1110_01) begin errors++; $display("FAIL edge1_addrBR got %b exp 111001", addrBR); end
    while (n < 13) step(1'b1);
    checks++; if (cycleEnd !== 1'b0) begin errors++; $display("FAIL cycleEnd_t13 got %0b exp 0", cycleEnd); end
    step(1'b1);
    checks++; if (cycleEnd !== 1'b1) begin errors++; $display("FAIL cycleEnd_t14 got %0b exp 1", cycleEnd); end
    step(1'b1);
    checks++; if (cycle !== 2'd1) begin errors++; $display("FAIL cycle_t15 got %0d exp 1", cycle); end
  endtask

  task automatic test_continuous();
    do_reset();
    for (int t = 1; t <= 60; t++) begin
      step(1'b1);
      checks++; if (cycle !== 2'((n / 15) % 4)) begin errors++; $display("FAIL cont_cycle n=%0d got %0d exp %0d", n, cycle, (n / 15) % 4); end
      checks++; if (cycleEnd !== (n % 15 == 14)) begin errors++; $display("FAIL cont_cycleEnd n=%0d got %0b", n, cycleEnd); end
      checks++; if (addrIn !== m_addrIn(n)) begin errors++; $display("FAIL cont_addrIn n=%0d got %0h exp %0h", n, addrIn, m_addrIn(n)); end
      checks++; if (addrLH !== m_addrLH(n)) begin errors++; $display("FAIL cont_addrLH n=%0d got %0h exp %0h", n, addrLH, m_addrLH(n)); end
      checks++; if (addrFR !== m_addrFR(n)) begin errors++; $display("FAIL cont_addrFR n=%0d got %0h exp %0h", n, addrFR, m_addrFR(n)); end
      checks++; if (addrBR !== m_addrBR(n)) begin errors++; $display("FAIL cont_addrBR n=%0d got %0h exp %0h", n, addrBR, m_addrBR(n)); end
    end
    checks++; if (cycle !== 2'd0) begin errors++; $display("FAIL cont_wrap_t60 got %0d exp 0", cycle); end
  endtask

  task automatic test_propagate_res();
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      step(1'b1);
      checks++; if (propagate !== m_prop(n)) begin errors++; $display("FAIL prop n=%0d got %0b exp %0b", n, propagate, m_prop(n)); end
      checks++; if (addrResIn !== m_resIn(n)) begin errors++; $display("FAIL resIn n=%0d got %0h exp %0h", n, addrResIn, m_resIn(n)); end
      checks++; if (addrResOutF !== m_resF(n)) begin errors++; $display("FAIL resOutF n=%0d got %0h exp %0h", n, addrResOutF, m_resF(n)); end
      checks++; if (addrResOutB !== m_resB(n)) begin errors++; $display("FAIL resOutB n=%0d got %0h exp %0h", n, addrResOutB, m_resB(n)); end
    end
  endtask

  task automatic test_sparse_en();
    do_reset();
    for (int t = 0; t < 32; t++) begin
      for (int c = 0; c < 12; c++) begin
        step(c == 0);
        checks++; if (addrIn !== m_addrIn(n)) begin errors++; $display("FAIL sparse_addrIn n=%0d got %0h exp %0h", n, addrIn, m_addrIn(n)); end
        checks++; if (addrBR !== m_addrBR(n)) begin errors++; $display("FAIL sparse_addrBR n=%0d got %0h exp %0h", n, addrBR, m_addrBR(n)); end
        checks++; if (addrResOutF !== m_resF(n)) begin errors++; $display("FAIL sparse_resF n=%0d got %0h exp %0h", n, addrResOutF, m_resF(n)); end
        checks++; if (propagate !== m_prop(n)) begin errors++; $display("FAIL sparse_prop n=%0d got %0b exp %0b", n, propagate, m_prop(n)); end
      end
    end
  endtask

  task automatic test_validity();
    do_reset();
    for (int t = 1; t <= 275; t++) begin
      step(1'b1);
      checks++; if (validCompute !== (n >= 46)) begin errors++; $display("FAIL validCompute n=%0d got %0b", n, validCompute); end
      checks++; if (valid !== (n >= 75)) begin errors++; $display("FAIL valid n=%0d got %0b", n, valid); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    while (n < 37) step(1'b1);
    checks++; if (cycle !== 2'd2) begin errors++; $display("FAIL mid_phase got %0d exp 2", cycle); end
    rst = 1'b0;
    step(1'b1);
    n = 0;
    rst = 1'b1;
    checks++; if (addrIn !== 6'd0) begin errors++; $display("FAIL mid_addrIn got %0h exp 0", addrIn); end
    checks++; if (addrResIn !== 5'd0) begin errors++; $display("FAIL mid_addrResIn got %0h exp 0", addrResIn); end
    checks++; if (propagate !== 1'b1) begin errors++; $display("FAIL mid_propagate got %0b exp 1", propagate); end
    checks++; if (cycle !== 2'd0) begin errors++; $display("FAIL mid_cycle got %0d exp 0", cycle); end
    checks++; if ({validCompute, valid} !== 2'b00) begin errors++; $display("FAIL mid_valid got %0b%0b exp 00", validCompute, valid); end
    for (int t = 1; t <= 20; t++) begin
      step(1'b1);
      checks++; if (addrIn !== m_addrIn(n)) begin errors++; $display("FAIL mid_restart_addrIn n=%0d got %0h exp %0h", n, addrIn, m_addrIn(n)); end
      checks++; if (addrLH !== m_addrLH(n)) begin errors++; $display("FAIL mid_restart_addrLH n=%0d got %0h exp %0h", n, addrLH, m_addrLH(n)); end
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_edge();
    test_continuous();
    test_propagate_res();
    test_sparse_en();
    test_validity();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
